// File: rtl/game_sequencer.sv
// game_sequencer: central controller for the T-Rex VGA game.
// Owns the game FSM (idle / run / dead), the scroll-speed ramp (dx) and the
// obstacle spawn scheduler, which talks to the obstacles block over a
// req/ack handshake. A free-running 16-bit Galois LFSR supplies the random
// spawn gap and obstacle type.
//
// Ports:
//   clk_i          system clock, single domain
//   rst_i          synchronous active-high reset
//   frame_tick_i   one-clk pulse per video frame
//   jump_i         debounced jump button (level)
//   collide_i      dino/obstacle overlap (level)
//   spawn_ack_i    obstacles block accepted the pending spawn
//   game_state_o   00 IDLE, 01 RUN, 10 DEAD
//   dx_o           current scroll speed, pixels/frame
//   spawn_req_o    spawn request, held until acknowledged
//   spawn_type_o   0 small cactus, 1 large cactus, 2 cactus group, 3 bird
//   score_en_o     score counter enable (high in RUN)
//   freeze_o       stops ground/obstacle motion (high outside RUN)
//
// State | meaning
// IDLE  | waiting for a jump press to start a run
// RUN   | game in progress: speed ramp and spawn scheduling active
// DEAD  | collision happened; restart accepted after DEAD_HOLD frames

module game_sequencer #(
    parameter int          DX_INIT     = 5,
    parameter int          DX_MAX      = 12,
    parameter int          RAMP_FRAMES = 600,
    parameter int          GAP_MIN     = 40,
    parameter int          GAP_MASK    = 63,
    parameter int          DEAD_HOLD   = 30,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       frame_tick_i,
    input  logic       jump_i,
    input  logic       collide_i,
    input  logic       spawn_ack_i,
    output logic [1:0] game_state_o,
    output logic [3:0] dx_o,
    output logic       spawn_req_o,
    output logic [1:0] spawn_type_o,
    output logic       score_en_o,
    output logic       freeze_o
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DEAD = 2'b10;

    localparam logic [3:0]  DX_INIT_C   = 4'(DX_INIT);
    localparam logic [3:0]  DX_MAX_C    = 4'(DX_MAX);
    localparam logic [9:0]  RAMP_LAST_C = 10'(RAMP_FRAMES - 1);
    localparam logic [7:0]  GAP_MIN_C   = 8'(GAP_MIN);
    localparam logic [7:0]  GAP_MASK_C  = 8'(GAP_MASK);
    localparam logic [5:0]  DEAD_HOLD_C = 6'(DEAD_HOLD);
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

    logic [1:0]  state_q, state_d;
    logic [3:0]  dx_q, dx_d;
    logic        spawn_req_q, spawn_req_d;
    logic [1:0]  spawn_type_q, spawn_type_d;
    logic        score_en_q, freeze_q;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  gap_q, gap_d;
    logic [9:0]  ramp_q, ramp_d;
    logic [5:0]  hold_q, hold_d;
    logic        jump_prev_q;

    logic jump_rise;
    logic ack;
    logic illegal;

    assign jump_rise = jump_i & ~jump_prev_q;
    // An ack only counts while a request is actually outstanding.
    assign ack       = spawn_ack_i & spawn_req_q;
    assign illegal   = (state_q == 2'b11);
    assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    always_comb begin
        state_d      = state_q;
        dx_d         = dx_q;
        spawn_req_d  = spawn_req_q;
        spawn_type_d = spawn_type_q;
        gap_d        = gap_q;
        ramp_d       = ramp_q;
        hold_d       = hold_q;

        case (state_q)
            ST_IDLE: begin
                if (jump_rise) begin
                    state_d = ST_RUN;
                    dx_d    = DX_INIT_C;
                    ramp_d  = 10'd0;
                    gap_d   = GAP_MIN_C;
                end
            end
            ST_RUN: begin
                if (collide_i) begin
                    // Collision wins over everything else this cycle.
                    state_d     = ST_DEAD;
                    spawn_req_d = 1'b0;
                    hold_d      = 6'd0;
                end else begin
                    if (ack) begin
                        spawn_req_d = 1'b0;
                        gap_d       = GAP_MIN_C + (lfsr_q[7:0] & GAP_MASK_C);
                    end
                    if (frame_tick_i) begin
                        if (ramp_q == RAMP_LAST_C) begin
                            ramp_d = 10'd0;
                            if (dx_q < DX_MAX_C) begin
                                dx_d = dx_q + 4'd1;
                            end
                        end else begin
                            ramp_d = ramp_q + 10'd1;
                        end
                        // Gap is frozen while a request is pending, which also
                        // keeps a freshly reloaded gap from being decremented.
                        if (!spawn_req_q && (gap_q != 8'd0)) begin
                            gap_d = gap_q - 8'd1;
                        end
                    end
                    // Request goes out on the same edge the gap reaches zero.
                    if (!spawn_req_q && (gap_d == 8'd0)) begin
                        spawn_req_d  = 1'b1;
                        spawn_type_d = lfsr_q[1:0];
                    end
                end
            end
            ST_DEAD: begin
                if (frame_tick_i && (hold_q != DEAD_HOLD_C)) begin
                    hold_d = hold_q + 6'd1;
                end
                if (jump_rise && (hold_q == DEAD_HOLD_C)) begin
                    state_d = ST_IDLE;
                    dx_d    = DX_INIT_C;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The unreachable encoding recovers exactly like a reset.
    always_ff @(posedge clk_i) begin
        if (rst_i || illegal) begin
            state_q      <= ST_IDLE;
            dx_q         <= DX_INIT_C;
            spawn_req_q  <= 1'b0;
            spawn_type_q <= 2'd0;
            score_en_q   <= 1'b0;
            freeze_q     <= 1'b1;
            lfsr_q       <= LFSR_SEED;
            gap_q        <= GAP_MIN_C;
            ramp_q       <= 10'd0;
            hold_q       <= 6'd0;
            jump_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dx_q         <= dx_d;
            spawn_req_q  <= spawn_req_d;
            spawn_type_q <= spawn_type_d;
            score_en_q   <= (state_d == ST_RUN);
            freeze_q     <= (state_d != ST_RUN);
            lfsr_q       <= lfsr_d;
            gap_q        <= gap_d;
            ramp_q       <= ramp_d;
            hold_q       <= hold_d;
            jump_prev_q  <= jump_i;
        end
    end

    assign game_state_o = state_q;
    assign dx_o         = dx_q;
    assign spawn_req_o  = spawn_req_q;
    assign spawn_type_o = spawn_type_q;
    assign score_en_o   = score_en_q;
    assign freeze_o     = freeze_q;

endmodule
